// File: rtl/contador_ad_param.sv
// Up/down RTC field counter: PS/2 arrow-key edit, cascaded tick with carry, load, runtime max.
// Latency: every update appears on Cuenta one clock after its strobe; edit_act is combinational.
// Backpressure: none; a tick that collides with load, range fix or edit is dropped.
module contador_ad_param #(
    parameter int         N       = 6,
    parameter int         MIN     = 0,
    parameter int         MAX     = 59,
    parameter int         USE_DYN = 0,
    parameter logic [1:0] SEL     = 2'd1,
    parameter logic [7:0] ST_A    = 8'h6C,
    parameter logic [7:0] ST_B    = 8'h75,
    parameter logic [7:0] K_UP    = 8'h73,
    parameter logic [7:0] K_DN    = 8'h72
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [7:0]   estado,
    input  logic [1:0]   en,
    input  logic [7:0]   Cambio,
    input  logic         got_data,
    input  logic         tick,
    input  logic [N-1:0] max_dyn,
    input  logic         load,
    input  logic [N-1:0] load_val,
    output logic [N-1:0] Cuenta,
    output logic         carry,
    output logic         edit_act
);

    localparam logic [N-1:0] MIN_V    = MIN[N-1:0];
    localparam logic [N-1:0] MAX_V    = MAX[N-1:0];
    localparam logic [7:0]   BRK_CODE = 8'hF0;

    typedef enum logic {F_IDLE, F_BREAK} filt_t;

    filt_t        filt, filt_nxt;
    logic [N-1:0] maxv_raw, maxv, load_clamp, cnt_nxt;
    logic         carry_nxt, key_ev;

    assign maxv_raw   = (USE_DYN != 0) ? max_dyn : MAX_V;
    assign maxv       = (maxv_raw < MIN_V) ? MIN_V : maxv_raw;
    assign load_clamp = (load_val < MIN_V) ? MIN_V :
                        (load_val > maxv)  ? maxv  : load_val;
    assign edit_act   = (en == SEL) && ((estado == ST_A) || (estado == ST_B));
    assign key_ev     = got_data && (filt == F_IDLE) && (Cambio != BRK_CODE);

    // The scan code following an F0 prefix is the key release; swallow it.
    always_comb begin
        filt_nxt = filt;
        if (got_data) begin
            filt_nxt = ((filt == F_IDLE) && (Cambio == BRK_CODE)) ? F_BREAK : F_IDLE;
        end
    end

    always_comb begin
        cnt_nxt   = Cuenta;
        carry_nxt = 1'b0;
        if (load) begin
            cnt_nxt = load_clamp;
        end else if (Cuenta > maxv) begin
            cnt_nxt = maxv;
        end else if (edit_act && key_ev && (Cambio == K_UP)) begin
            cnt_nxt = (Cuenta == maxv) ? MIN_V : Cuenta + 1'b1;
        end else if (edit_act && key_ev && (Cambio == K_DN)) begin
            cnt_nxt = (Cuenta == MIN_V) ? maxv : Cuenta - 1'b1;
        end else if (tick) begin
            if (Cuenta == maxv) begin
                cnt_nxt   = MIN_V;
                carry_nxt = 1'b1;
            end else begin
                cnt_nxt = Cuenta + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            Cuenta <= MIN_V;
            carry  <= 1'b0;
            filt   <= F_IDLE;
        end else begin
            Cuenta <= cnt_nxt;
            carry  <= carry_nxt;
            filt   <= filt_nxt;
        end
    end

endmodule

// File: tb/tb_contador_ad_param.sv
// Bench for contador_ad_param: a fixed 0..59 instance and a dynamic-max 1..31 instance.
// Expected values are queued as stimulus is driven and compared one clock later.
module tb_contador_ad_param;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] estado, cambio;
    logic [1:0] en;
    logic       got_data;
    logic       a_tick, a_load, b_tick, b_load;
    logic [5:0] a_load_val, b_load_val, a_max_dyn, b_max_dyn;
    logic [5:0] a_cnt, b_cnt;
    logic       a_cy, b_cy, a_edit, b_edit;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string      tag;
        logic [5:0] a_cnt;
        logic       a_cy;
        logic [5:0] b_cnt;
        logic       b_cy;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    contador_ad_param u_a (
        .clk(clk), .rst(rst), .estado(estado), .en(en), .Cambio(cambio),
        .got_data(got_data), .tick(a_tick), .max_dyn(a_max_dyn), .load(a_load),
        .load_val(a_load_val), .Cuenta(a_cnt), .carry(a_cy), .edit_act(a_edit)
    );

    contador_ad_param #(.N(6), .MIN(1), .MAX(31), .USE_DYN(1), .SEL(2'd2)) u_b (
        .clk(clk), .rst(rst), .estado(estado), .en(en), .Cambio(cambio),
        .got_data(got_data), .tick(b_tick), .max_dyn(b_max_dyn), .load(b_load),
        .load_val(b_load_val), .Cuenta(b_cnt), .carry(b_cy), .edit_act(b_edit)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Inputs are already set up at the falling edge; this queues the expectation,
    // lets one rising edge pass, then compares at the next falling edge.
    task automatic cyc(input string tag, input logic [5:0] ea, input logic eca,
                       input logic [5:0] eb, input logic ecb);
        exp_t e;
        exp_t r;
        e.tag = tag; e.a_cnt = ea; e.a_cy = eca; e.b_cnt = eb; e.b_cy = ecb;
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        r = sb.pop_front();
        chk({r.tag, ".a_cnt"}, 32'(a_cnt), 32'(r.a_cnt));
        chk({r.tag, ".a_cy"},  32'(a_cy),  32'(r.a_cy));
        chk({r.tag, ".b_cnt"}, 32'(b_cnt), 32'(r.b_cnt));
        chk({r.tag, ".b_cy"},  32'(b_cy),  32'(r.b_cy));
        rst = 1'b0; got_data = 1'b0; a_tick = 1'b0; b_tick = 1'b0;
        a_load = 1'b0; b_load = 1'b0;
    endtask

    task automatic key(input logic [7:0] code);
        got_data = 1'b1;
        cambio   = code;
    endtask

    task automatic a_ld(input logic [5:0] v);
        a_load     = 1'b1;
        a_load_val = v;
    endtask

    initial begin
        rst = 1'b0; estado = 8'h00; en = 2'd0; cambio = 8'h00; got_data = 1'b0;
        a_tick = 1'b0; a_load = 1'b0; a_load_val = '0; a_max_dyn = '0;
        b_tick = 1'b0; b_load = 1'b0; b_load_val = '0; b_max_dyn = 6'd31;
        @(negedge clk);

        rst = 1'b1;                   cyc("reset",       6'd0,  1'b0, 6'd1,  1'b0);

        en = 2'd1; estado = 8'h6C; #1;
        chk("edit_act_st_a", 32'(a_edit), 32'd1);
        chk("edit_act_other_sel", 32'(b_edit), 32'd0);
        estado = 8'h75; #1;
        chk("edit_act_st_b", 32'(a_edit), 32'd1);
        estado = 8'h10; #1;
        chk("edit_act_bad_state", 32'(a_edit), 32'd0);
        estado = 8'h6C;
        @(negedge clk);

        a_ld(6'd59);                  cyc("load59",      6'd59, 1'b0, 6'd1,  1'b0);
        key(8'h73);                   cyc("up_wrap",     6'd0,  1'b0, 6'd1,  1'b0);
        key(8'h72);                   cyc("dn_wrap",     6'd59, 1'b0, 6'd1,  1'b0);
        key(8'h72);                   cyc("dn",          6'd58, 1'b0, 6'd1,  1'b0);

        a_ld(6'd5);                   cyc("load5",       6'd5,  1'b0, 6'd1,  1'b0);
        key(8'hF0);                   cyc("f0_noact",    6'd5,  1'b0, 6'd1,  1'b0);
        key(8'h73);                   cyc("break_swal",  6'd5,  1'b0, 6'd1,  1'b0);
        key(8'h73);                   cyc("after_break", 6'd6,  1'b0, 6'd1,  1'b0);
        key(8'h10);                   cyc("other_key",   6'd6,  1'b0, 6'd1,  1'b0);

        a_ld(6'd59);                  cyc("load59b",     6'd59, 1'b0, 6'd1,  1'b0);
        a_tick = 1'b1;                cyc("tick_wrap",   6'd0,  1'b1, 6'd1,  1'b0);
                                      cyc("carry_1clk",  6'd0,  1'b0, 6'd1,  1'b0);
        a_tick = 1'b1;                cyc("tick_inc",    6'd1,  1'b0, 6'd1,  1'b0);
        a_ld(6'd59);                  cyc("load59c",     6'd59, 1'b0, 6'd1,  1'b0);
        a_tick = 1'b1; key(8'h73);    cyc("tick_edit_up",6'd0,  1'b0, 6'd1,  1'b0);
        a_ld(6'd59);                  cyc("load59d",     6'd59, 1'b0, 6'd1,  1'b0);
        a_tick = 1'b1; key(8'h72);    cyc("tick_edit_dn",6'd58, 1'b0, 6'd1,  1'b0);
        a_tick = 1'b1; a_ld(6'd3);    cyc("tick_load",   6'd3,  1'b0, 6'd1,  1'b0);

        a_ld(6'd60);                  cyc("load_clamp",  6'd59, 1'b0, 6'd1,  1'b0);
        en = 2'd0; key(8'h73);        cyc("not_sel",     6'd59, 1'b0, 6'd1,  1'b0);
        en = 2'd1; estado = 8'h10;
        key(8'h73);                   cyc("bad_state",   6'd59, 1'b0, 6'd1,  1'b0);
        estado = 8'h6C;

        key(8'hF0);                   cyc("f0_pre_rst",  6'd59, 1'b0, 6'd1,  1'b0);
        rst = 1'b1;                   cyc("rst_mid_brk", 6'd0,  1'b0, 6'd1,  1'b0);
        key(8'h73);                   cyc("post_rst_key",6'd1,  1'b0, 6'd1,  1'b0);

        en = 2'd0;
        b_load = 1'b1; b_load_val = 6'd31;
                                      cyc("b_load31",    6'd1,  1'b0, 6'd31, 1'b0);
        b_max_dyn = 6'd28;            cyc("b_range_fix", 6'd1,  1'b0, 6'd28, 1'b0);
        b_tick = 1'b1;                cyc("b_tick_wrap", 6'd1,  1'b0, 6'd1,  1'b1);
        b_tick = 1'b1;                cyc("b_tick_inc",  6'd1,  1'b0, 6'd2,  1'b0);
        b_load = 1'b1; b_load_val = 6'd0;
                                      cyc("b_load_min",  6'd1,  1'b0, 6'd1,  1'b0);
        b_max_dyn = 6'd0; b_tick = 1'b1;
                                      cyc("b_maxv_lt_min",6'd1, 1'b0, 6'd1,  1'b1);
        b_max_dyn = 6'd31;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
